// File: rtl/fyra_ctrl_pkg.sv
// Shared types and constants for the 5-stage core's sequencing control.
// The saturating increment is shared with any other perf counters.
package fyra_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pipe_state_t;

    localparam int REG_ZERO    = 0;
    localparam int STALL_CNT_W = 16;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        logic [STALL_CNT_W-1:0] r;
        if (v == {STALL_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + STALL_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// Kept separate so the forwarding unit can share the same compare.
module hazard_unit
    import fyra_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic            uses_rs1,
    input  logic            uses_rs2,
    input  logic [RA_W-1:0] rd,
    input  logic            mem_read,
    output logic            load_use
);

    logic rd_live_s;
    logic match_s;

    // x0 never carries a real dependency, so a load to it never stalls
    always_comb begin
        rd_live_s = (rd != RA_W'(REG_ZERO));
        match_s   = (uses_rs1 & (rs1 == rd)) | (uses_rs2 & (rs2 == rd));
        load_use  = mem_read & rd_live_s & match_s;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: boot hold, branch redirect, load-use
// stall, memory freeze and halt/resume, plus a stall-cycle perf counter.
module pipe_ctrl
    import fyra_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RA_W        = 5,
    parameter int BOOT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RA_W-1:0]        idRs1,
    input  logic [RA_W-1:0]        idRs2,
    input  logic                   idUsesRs1,
    input  logic                   idUsesRs2,
    input  logic [RA_W-1:0]        exRd,
    input  logic                   exMemRead,
    input  logic                   exBrTaken,
    input  logic [XLEN-1:0]        exBrTarget,
    input  logic                   memBusy,
    input  logic                   haltReq,
    input  logic                   resumeReq,
    output logic                   pcEn,
    output logic                   branchSel,
    output logic [XLEN-1:0]        branchVal,
    output logic                   ifidEn,
    output logic                   idexEn,
    output logic                   exmemEn,
    output logic                   ifidFlush,
    output logic                   idexFlush,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stallCount
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_CYCLES - 1);

    pipe_state_t            state_r;
    logic [BOOT_W-1:0]      boot_cnt_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   load_use_s;
    logic                   halt_entry_s;

    hazard_unit #(.RA_W(RA_W)) u_hazard (
        .rs1      (idRs1),
        .rs2      (idRs2),
        .uses_rs1 (idUsesRs1),
        .uses_rs2 (idUsesRs2),
        .rd       (exRd),
        .mem_read (exMemRead),
        .load_use (load_use_s)
    );

    // Halt is only accepted when nothing of higher priority claims the cycle
    always_comb begin
        halt_entry_s = ~memBusy & ~exBrTaken & ~load_use_s & haltReq;
    end

    // Priority mux: reset forces the boot pattern regardless of stored state
    always_comb begin
        pcEn      = 1'b0;
        branchSel = 1'b0;
        branchVal = exBrTarget;
        ifidEn    = 1'b0;
        idexEn    = 1'b0;
        exmemEn   = 1'b0;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        halted    = 1'b0;
        if (rst) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else begin
            case (state_r)
                BOOT: begin
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                end
                RUN: begin
                    if (memBusy) begin
                        pcEn = 1'b0;
                    end else if (exBrTaken) begin
                        pcEn      = 1'b1;
                        branchSel = 1'b1;
                        ifidEn    = 1'b1;
                        idexEn    = 1'b1;
                        exmemEn   = 1'b1;
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                    end else if (load_use_s) begin
                        idexEn    = 1'b1;
                        exmemEn   = 1'b1;
                        idexFlush = 1'b1;
                    end else if (haltReq) begin
                        idexEn    = 1'b1;
                        exmemEn   = 1'b1;
                        idexFlush = 1'b1;
                    end else begin
                        pcEn    = 1'b1;
                        ifidEn  = 1'b1;
                        idexEn  = 1'b1;
                        exmemEn = 1'b1;
                    end
                end
                HALT: begin
                    // Front end held; back end drains unless memory is busy
                    idexEn    = ~memBusy;
                    exmemEn   = ~memBusy;
                    idexFlush = 1'b1;
                    halted    = 1'b1;
                end
                default: begin
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                end
            endcase
        end
    end

    // State, boot countdown and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= BOOT;
            boot_cnt_r  <= BOOT_LOAD;
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else begin
            case (state_r)
                BOOT: begin
                    if (boot_cnt_r == {BOOT_W{1'b0}}) begin
                        state_r <= RUN;
                    end else begin
                        boot_cnt_r <= boot_cnt_r - BOOT_W'(1);
                    end
                end
                RUN: begin
                    if (halt_entry_s) begin
                        state_r <= HALT;
                    end else begin
                        state_r <= RUN;
                    end
                    if (!pcEn) begin
                        stall_cnt_r <= sat_inc(stall_cnt_r);
                    end else begin
                        stall_cnt_r <= stall_cnt_r;
                    end
                end
                HALT: begin
                    if (resumeReq && !memBusy) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= HALT;
                    end
                end
                default: begin
                    state_r    <= BOOT;
                    boot_cnt_r <= BOOT_LOAD;
                end
            endcase
        end
    end

    assign stallCount = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios followed by random
// traffic, checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int BOOT = 2;

    typedef struct packed {
        logic        pc_en;
        logic        br_sel;
        logic [31:0] br_val;
        logic        ifid_en;
        logic        idex_en;
        logic        exmem_en;
        logic        ifid_fl;
        logic        idex_fl;
        logic        halted;
        logic [15:0] stalls;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic [RA_W-1:0] idRs1, idRs2, exRd;
    logic idUsesRs1, idUsesRs2, exMemRead, exBrTaken, memBusy, haltReq, resumeReq;
    logic [XLEN-1:0] exBrTarget;
    logic pcEn, branchSel, ifidEn, idexEn, exmemEn, ifidFlush, idexFlush, halted;
    logic [XLEN-1:0] branchVal;
    logic [15:0] stallCount;

    int vectors = 0;
    int miscompares = 0;
    obs_t exp_q[$];

    // model state: boot cycles still to show, halted flag, stall tally
    int m_boot_left;
    bit m_halted;
    int m_stalls;

    always #5 clk = ~clk;

    pipe_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .BOOT_CYCLES(BOOT)) dut (
        .clk(clk), .rst(rst),
        .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .exRd(exRd), .exMemRead(exMemRead), .exBrTaken(exBrTaken), .exBrTarget(exBrTarget),
        .memBusy(memBusy), .haltReq(haltReq), .resumeReq(resumeReq),
        .pcEn(pcEn), .branchSel(branchSel), .branchVal(branchVal),
        .ifidEn(ifidEn), .idexEn(idexEn), .exmemEn(exmemEn),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush),
        .halted(halted), .stallCount(stallCount)
    );

    task automatic step(input bit r, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit mr, input bit br, input logic [31:0] tgt,
                        input bit mb, input bit hq, input bit rq);
        obs_t e;
        bit hazard, halting;
        rst = r; idRs1 = RA_W'(rs1); idRs2 = RA_W'(rs2); idUsesRs1 = u1; idUsesRs2 = u2;
        exRd = RA_W'(rd); exMemRead = mr; exBrTaken = br; exBrTarget = tgt;
        memBusy = mb; haltReq = hq; resumeReq = rq;
        hazard  = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        halting = 1'b0;
        e = '0;
        e.br_val = tgt;
        e.stalls = 16'(m_stalls);
        if (r || m_boot_left > 0) begin
            e.ifid_fl = 1'b1; e.idex_fl = 1'b1;
        end else if (m_halted) begin
            e.halted = 1'b1; e.idex_fl = 1'b1; e.idex_en = !mb; e.exmem_en = !mb;
        end else if (mb) begin
            e.pc_en = 1'b0;
        end else if (br) begin
            e.pc_en = 1'b1; e.br_sel = 1'b1; e.ifid_en = 1'b1; e.idex_en = 1'b1;
            e.exmem_en = 1'b1; e.ifid_fl = 1'b1; e.idex_fl = 1'b1;
        end else if (hazard || hq) begin
            e.idex_en = 1'b1; e.exmem_en = 1'b1; e.idex_fl = 1'b1;
            halting = !hazard;
        end else begin
            e.pc_en = 1'b1; e.ifid_en = 1'b1; e.idex_en = 1'b1; e.exmem_en = 1'b1;
        end
        exp_q.push_back(e);
        // advance the model across the coming edge
        if (r) begin
            m_boot_left = BOOT; m_halted = 1'b0; m_stalls = 0;
        end else if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (m_halted) begin
            if (rq && !mb) m_halted = 1'b0;
        end else begin
            if (!e.pc_en && m_stalls < 65535) m_stalls++;
            if (halting) m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 2, 1, 1, 3, 0, 0, 32'h0000_0040, 0, 0, 0);
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clk) begin
        obs_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pcEn, branchSel, branchVal, ifidEn, idexEn, exmemEn,
                 ifidFlush, idexFlush, halted, stallCount};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t got pc=%b bs=%b bv=%h en=%b%b%b fl=%b%b h=%b sc=%0d want pc=%b bs=%b bv=%h en=%b%b%b fl=%b%b h=%b sc=%0d",
                         $time, a.pc_en, a.br_sel, a.br_val, a.ifid_en, a.idex_en, a.exmem_en,
                         a.ifid_fl, a.idex_fl, a.halted, a.stalls,
                         e.pc_en, e.br_sel, e.br_val, e.ifid_en, e.idex_en, e.exmem_en,
                         e.ifid_fl, e.idex_fl, e.halted, e.stalls);
            end
        end
    end

    initial begin
        rst = 1'b1; idRs1 = '0; idRs2 = '0; idUsesRs1 = 1'b0; idUsesRs2 = 1'b0;
        exRd = '0; exMemRead = 1'b0; exBrTaken = 1'b0; exBrTarget = '0;
        memBusy = 1'b0; haltReq = 1'b0; resumeReq = 1'b0;
        m_boot_left = BOOT; m_halted = 1'b0; m_stalls = 0;
        @(posedge clk); @(posedge clk); #1;
        // reset held, then boot release and a few normal cycles
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        nop(4);
        // load-use through rs2, then the bubble sits in EX
        step(0, 1, 5, 0, 1, 5, 1, 0, 32'h0, 0, 0, 0);
        nop(1);
        // x0 destination and unused matching source
        step(0, 0, 0, 1, 1, 0, 1, 0, 32'h0, 0, 0, 0);
        step(0, 7, 2, 0, 1, 7, 1, 0, 32'h0, 0, 0, 0);
        // redirect beats a simultaneous load-use
        step(0, 5, 5, 1, 1, 5, 1, 1, 32'h0000_0100, 0, 0, 0);
        // frozen branch re-presented after three busy cycles
        for (int i = 0; i < 3; i++) step(0, 1, 2, 1, 1, 3, 0, 1, 32'h0000_0200, 1, 0, 0);
        step(0, 1, 2, 1, 1, 3, 0, 1, 32'h0000_0200, 0, 0, 0);
        // branch with halt, then load-use with halt, then halt taken
        step(0, 1, 2, 1, 1, 3, 0, 1, 32'h0000_0300, 0, 1, 0);
        step(0, 4, 2, 1, 1, 4, 1, 0, 32'h0, 0, 1, 0);
        step(0, 1, 2, 1, 1, 3, 0, 0, 32'h0, 0, 1, 0);
        step(0, 1, 2, 1, 1, 3, 0, 0, 32'h0, 0, 1, 0);
        step(0, 1, 2, 1, 1, 3, 0, 0, 32'h0, 1, 0, 1);
        step(0, 1, 2, 1, 1, 3, 0, 0, 32'h0, 1, 0, 1);
        step(0, 1, 2, 1, 1, 3, 0, 0, 32'h0, 0, 0, 1);
        nop(2);
        // halt again, reset while halted
        step(0, 1, 2, 1, 1, 3, 0, 0, 32'h0, 0, 1, 0);
        step(0, 1, 2, 1, 1, 3, 0, 0, 32'h0, 0, 1, 0);
        step(1, 1, 2, 1, 1, 3, 0, 0, 32'h0, 0, 1, 0);
        nop(4);
        // random traffic with small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 6) == 0, $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0);
        end
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
